instr_encoder: RTL and testbench

//  Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready

---
 rtl/instr_encoder.sv | 235 +++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs decoded instruction fields into 16-bit instruction words and queues
//   them in a small FIFO for the instruction-memory loader.
//   A wide MOVI expands into two words (low byte first, then high byte).
//   Illegal or out-of-range requests are accepted, dropped and flagged.
//
// Ports
//   clk_pi, reset_n_pi          clock, asynchronous active-low reset
//   in_valid_pi / in_ready_po   request handshake
//   op_pi, rd_pi, rs1_pi,
//   rs2_pi, func_pi, imm_pi,
//   wide_pi                     decoded instruction fields
//   out_valid_po / out_ready_pi output handshake (FIFO head)
//   out_data_po                 FIFO head word, zero when empty
//   err_po                      one-cycle pulse for a dropped request
//   err_count_po                saturating count of dropped requests
//   words_po                    total words pushed, wrapping
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_pi,
    input  logic                 reset_n_pi,
    input  logic                 in_valid_pi,
    output logic                 in_ready_po,
    input  logic [3:0]           op_pi,
    input  logic [2:0]           rd_pi,
    input  logic [2:0]           rs1_pi,
    input  logic [2:0]           rs2_pi,
    input  logic [2:0]           func_pi,
    input  logic [15:0]          imm_pi,
    input  logic                 wide_pi,
    output logic                 out_valid_po,
    input  logic                 out_ready_pi,
    output logic [15:0]          out_data_po,
    output logic                 err_po,
    output logic [ERR_CNT_W-1:0] err_count_po,
    output logic [15:0]          words_po
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ARITH2 = 4'h1;
    localparam logic [3:0] OP_ARITH1 = 4'h2;
    localparam logic [3:0] OP_MOVI  = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_SUBI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STOR  = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_BGE   = 4'h9;
    localparam logic [3:0] OP_BLE   = 4'hA;
    localparam logic [3:0] OP_BC    = 4'hB;
    localparam logic [3:0] OP_J     = 4'hC;
    localparam logic [3:0] OP_CTRL  = 4'hF;

    typedef enum logic {S_IDLE, S_HI} state_t;

    state_t               state_q, state_d;
    logic [15:0]          hi_word_q;
    logic [15:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [15:0]          words_q;

    logic        legal;
    logic        is_wide;
    logic [15:0] word0, word1;
    logic        handshake;
    logic        push;
    logic [15:0] push_data;
    logic        pop;
    logic        fifo_full, fifo_empty;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & out_ready_pi;
    assign handshake  = in_valid_pi & in_ready_po;

    // ------------------------------------------------------------------
    // Field packing and legality check
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        legal   = 1'b0;
        is_wide = 1'b0;
        word0   = '0;
        word1   = '0;
        unique case (op_pi)
            OP_NOP: begin
                legal = 1'b1;
            end
            OP_ARITH2, OP_ARITH1: begin
                legal = 1'b1;
                word0 = {op_pi, rd_pi, rs1_pi, rs2_pi, func_pi};
            end
            OP_MOVI: begin
                word0 = {op_pi, rd_pi, 1'b0, imm_pi[7:0]};
                word1 = {op_pi, rd_pi, 1'b1, imm_pi[15:8]};
                if (wide_pi) begin
                    legal   = 1'b1;
                    is_wide = 1'b1;
                end else begin
                    legal = (imm_pi[15:8] == 8'h00);
                end
            end
            OP_ADDI, OP_SUBI, OP_LOAD, OP_STOR, OP_BEQ, OP_BGE, OP_BLE: begin
                legal = (imm_pi[15:6] == 10'h000);
                word0 = {op_pi, rd_pi, rs1_pi, imm_pi[5:0]};
            end
            OP_BC, OP_J: begin
                legal = (imm_pi[15:12] == 4'h0);
                word0 = {op_pi, imm_pi[11:0]};
            end
            OP_CTRL: begin
                legal = (imm_pi == 16'h0001) || (imm_pi == 16'h0002) ||
                        (imm_pi == 16'h0AAA) || (imm_pi == 16'h0FFF);
                word0 = {op_pi, imm_pi[11:0]};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every register samples pre-edge values.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (handshake && legal && is_wide) state_d = S_HI;
            S_HI:   if (!fifo_full)                    state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_po = 1'b0;
        push        = 1'b0;
        push_data   = '0;
        unique case (state_q)
            S_IDLE: begin
                // Gated by reset so the upstream never sees ready during reset.
                in_ready_po = reset_n_pi & ~fifo_full;
                if (handshake && legal) begin
                    push      = 1'b1;
                    push_data = word0;
                end
            end
            S_HI: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = hi_word_q;
                end
            end
            default: ;
        endcase
    end

    // High byte of a wide MOVI, captured at accept and pushed from S_HI.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            hi_word_q <= '0;
        end else if (state_q == S_IDLE && handshake) begin
            hi_word_q <= word1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; out_data_po is forced to zero
    // while empty, so stale contents are never observable.
    always_ff @(posedge clk_pi) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Fullness is taken before any same-cycle pop, so a pop never makes
    // room for a push in that cycle.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    assign out_valid_po = ~fifo_empty;
    assign out_data_po  = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Status and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            words_q   <= '0;
        end else begin
            err_q <= handshake & ~legal;
            if (handshake && !legal && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            if (push)
                words_q <= words_q + 16'd1;
        end
    end

    assign err_po       = err_q;
    assign err_count_po = err_cnt_q;
    assign words_po     = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed-vector bench for instr_encoder. Each task drives one scenario
//   and compares DUT outputs against hand-computed instruction words.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2, func;
    logic [15:0] imm;
    logic        wide;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] words;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
        .clk_pi       (clk),
        .reset_n_pi   (reset_n),
        .in_valid_pi  (in_valid),
        .in_ready_po  (in_ready),
        .op_pi        (op),
        .rd_pi        (rd),
        .rs1_pi       (rs1),
        .rs2_pi       (rs2),
        .func_pi      (func),
        .imm_pi       (imm),
        .wide_pi      (wide),
        .out_valid_po (out_valid),
        .out_ready_pi (out_ready),
        .out_data_po  (out_data),
        .err_po       (err),
        .err_count_po (err_count),
        .words_po     (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request and holds it until the handshake edge; returns
    // 1 ns after that edge. A request never accepted counts as a failure.
    task automatic send(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] f, input logic [15:0] im,
                        input logic w);
        bit done = 0;
        op = o; rd = d; rs1 = s1; rs2 = s2; func = f; imm = im; wide = w;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: op=%h not accepted, in_ready=%b required 1", o, in_ready);
        end else begin
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        wide = 1'b0;
    endtask

    // Waits for a head word, compares it and pops it; returns 1 ns after the pop edge.
    task automatic pop_expect(input string name, input logic [15:0] exp);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || out_data !== exp) begin
            errors++;
            $display("FAIL %s: out_valid=%b out_data=%h required %h", name, out_valid, out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; func = '0; imm = '0; wide = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, err, err_count, words} !== 43'h0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h err=%b ecnt=%0d words=%0d required all 0",
                     in_ready, out_valid, out_data, err, err_count, words);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_arith();
        send(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 16'h0000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1298 || words !== 16'd1) begin
            errors++;
            $display("FAIL add_latency: vld=%b data=%h words=%0d required 1 1298 1", out_valid, out_data, words);
        end
        pop_expect("add_pop", 16'h1298);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_empty: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_wide_movi();
        send(4'h3, 3'd2, 3'd0, 3'd0, 3'd0, 16'hBEEF, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 16'h34EF) begin
            errors++;
            $display("FAIL movi_hi_state: in_ready=%b data=%h required 0 34EF", in_ready, out_data);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || words !== 16'd3) begin
            errors++;
            $display("FAIL movi_done: in_ready=%b words=%0d required 1 3", in_ready, words);
        end
        pop_expect("movi_lo", 16'h34EF);
        pop_expect("movi_hi", 16'h35BE);
    endtask

    task automatic test_control();
        send(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0FFF, 1'b0);
        pop_expect("ctrl_halt", 16'hFFFF);
        send(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0123, 1'b0);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0 || words !== 16'd4) begin
            errors++;
            $display("FAIL ctrl_bad: err=%b ecnt=%0d vld=%b words=%0d required 1 1 0 4",
                     err, err_count, out_valid, words);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width: err=%b required 0", err);
        end
    endtask

    task automatic test_range_errors();
        send(4'h4, 3'd1, 3'd2, 3'd0, 3'd0, 16'h0040, 1'b0);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_range: err=%b ecnt=%0d vld=%b required 1 2 0", err, err_count, out_valid);
        end
        send(4'hD, 3'd1, 3'd2, 3'd3, 3'd4, 16'h0000, 1'b0);
        checks++;
        if (err !== 1'b1 || err_count !== 8'd3 || out_valid !== 1'b0 || words !== 16'd4) begin
            errors++;
            $display("FAIL op_d_illegal: err=%b ecnt=%0d vld=%b words=%0d required 1 3 0 4",
                     err, err_count, out_valid, words);
        end
        send(4'h4, 3'd1, 3'd2, 3'd0, 3'd0, 16'h003F, 1'b0);
        pop_expect("addi_ok", 16'h42BF);
        send(4'hC, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0123, 1'b0);
        pop_expect("jump", 16'hC123);
        checks++;
        if (words !== 16'd6 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL after_errors: words=%0d ecnt=%0d required 6 3", words, err_count);
        end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) send(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || words !== 16'd10) begin
            errors++;
            $display("FAIL fifo_full: in_ready=%b words=%0d required 0 10", in_ready, words);
        end
        pop_expect("nop0", 16'h0000);
        send(4'h3, 3'd1, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || words !== 16'd11) begin
            errors++;
            $display("FAIL hi_stall: in_ready=%b words=%0d required 0 11", in_ready, words);
        end
        pop_expect("nop1", 16'h0000);
        pop_expect("nop2", 16'h0000);
        pop_expect("nop3", 16'h0000);
        pop_expect("stall_lo", 16'h3234);
        pop_expect("stall_hi", 16'h3312);
        checks++;
        if (out_valid !== 1'b0 || words !== 16'd12) begin
            errors++;
            $display("FAIL drain_done: vld=%b words=%0d required 0 12", out_valid, words);
        end
    endtask

    task automatic test_back_to_back();
        send(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 16'h0000, 1'b0);
        out_ready = 1'b1;
        send(4'h2, 3'd7, 3'd7, 3'd0, 3'd5, 16'h0000, 1'b0);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h2FC5 || words !== 16'd14) begin
            errors++;
            $display("FAIL push_pop: vld=%b data=%h words=%0d required 1 2FC5 14", out_valid, out_data, words);
        end
        pop_expect("push_pop_tail", 16'h2FC5);
    endtask

    task automatic test_reset_in_hi();
        send(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
        send(4'h3, 3'd4, 3'd0, 3'd0, 3'd0, 16'hA55A, 1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, err, err_count, words} !== 43'h0) begin
            errors++;
            $display("FAIL reset_in_hi: rdy=%b vld=%b data=%h err=%b ecnt=%0d words=%0d required all 0",
                     in_ready, out_valid, out_data, err, err_count, words);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || words !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hi_discarded: vld=%b data=%h words=%0d rdy=%b required 0 0 1",
                     out_valid, out_data, words, in_ready);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) send(4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
        checks++;
        if (err_count !== 8'hFF || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_saturate: ecnt=%0d vld=%b required 255 0", err_count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_wide_movi();
        test_control();
        test_range_errors();
        test_full_stall();
        test_back_to_back();
        test_reset_in_hi();
        test_err_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
